// File: rtl/if_neuron_pkg.sv
// if_neuron_pkg: shared types and helpers for the integrate-and-fire update
// pipe.
//   op_e         - command opcodes as they appear on cmd_op
//   fsm_state_e  - control FSM states (RUN accepts commands, CLEAR sweeps)
//   pipe_stage_t - one pipe slot {valid, op, addr, weight}; the address and
//                  weight fields are sized for the widest supported
//                  configuration. The top zero-extends addresses and
//                  sign-extends weights into them.
//   sat_add      - signed add clamped to the range of a w-bit signed value
package if_neuron_pkg;

  localparam int PIPE_ADDR_W   = 16;
  localparam int PIPE_WEIGHT_W = 16;

  typedef enum logic [1:0] {
    OP_SYN     = 2'b00,
    OP_STEP    = 2'b01,
    OP_REF     = 2'b10,
    OP_CLR_ALL = 2'b11
  } op_e;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } fsm_state_e;

  typedef struct packed {
    logic                              valid;
    op_e                               op;
    logic [PIPE_ADDR_W-1:0]            addr;
    logic signed [PIPE_WEIGHT_W-1:0]   weight;
  } pipe_stage_t;

  // Operands are kept far below 32 bits, so the raw sum cannot wrap before
  // it is clamped to the w-bit rails.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [31:0] s;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    s  = a + b;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (s > hi)      return hi;
    else if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/if_neuron_alu.sv
// if_neuron_alu: combinational S1 datapath of the neuron update pipe.
//   i_op          operation in S1
//   i_state/i_cnt forwarded membrane state and spike count
//   i_weight      sign-extended synaptic weight (SYN only)
//   i_thr         signed firing threshold
//   i_leak_en     apply shift leak on STEP
//   i_leak_shift  leak = state >>> shift
//   i_reset_sub   1: subtract threshold on spike, 0: reset to zero
//   o_state/o_cnt updated state and count
//   o_spike       STEP crossed the threshold
module if_neuron_alu
  import if_neuron_pkg::*;
#(
  parameter int MEM_W = 12,
  parameter int CNT_W = 7,
  parameter int SH_W  = 4
) (
  input  op_e                             i_op,
  input  logic signed [MEM_W-1:0]         i_state,
  input  logic [CNT_W-1:0]                i_cnt,
  input  logic signed [PIPE_WEIGHT_W-1:0] i_weight,
  input  logic signed [MEM_W-1:0]         i_thr,
  input  logic                            i_leak_en,
  input  logic [SH_W-1:0]                 i_leak_shift,
  input  logic                            i_reset_sub,
  output logic signed [MEM_W-1:0]         o_state,
  output logic [CNT_W-1:0]                o_cnt,
  output logic                            o_spike
);

  logic signed [MEM_W-1:0] w_leak;
  logic signed [31:0]      w_st32;
  logic signed [31:0]      w_wt32;
  logic signed [31:0]      w_thr32;
  logic signed [31:0]      w_v32;
  logic                    w_fire;
  logic [CNT_W-1:0]        w_cnt_inc;

  assign w_leak  = i_state >>> i_leak_shift;
  assign w_st32  = 32'(i_state);
  assign w_wt32  = 32'(i_weight);
  assign w_thr32 = 32'(i_thr);
  // state - (state >>> shift) always stays inside the MEM_W range.
  assign w_v32   = i_leak_en ? (w_st32 - 32'(w_leak)) : w_st32;
  assign w_fire  = (w_v32 >= w_thr32);
  // Count saturates: a neuron already at the top keeps the top value.
  assign w_cnt_inc = (&i_cnt) ? i_cnt : (i_cnt + CNT_W'(1));

  always_comb begin
    o_state = i_state;
    o_cnt   = i_cnt;
    o_spike = 1'b0;
    case (i_op)
      OP_SYN: begin
        o_state = MEM_W'(sat_add(w_st32, w_wt32, MEM_W));
      end
      OP_STEP: begin
        if (w_fire) begin
          o_spike = 1'b1;
          o_cnt   = w_cnt_inc;
          o_state = i_reset_sub ? MEM_W'(sat_add(w_v32, -w_thr32, MEM_W)) : '0;
        end else begin
          o_state = MEM_W'(w_v32);
        end
      end
      OP_REF: begin
        o_state = '0;
        o_cnt   = '0;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/if_neuron_pipe.sv
// if_neuron_pipe: pipelined integrate-and-fire update engine in front of a
// 1-cycle-latency neuron-state SRAM.
//   CLK, RST                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_op/cmd_addr/cmd_weight   opcode, neuron, signed weight
//   cfg_*                        threshold, leak and reset-mode config (used in S1)
//   mem_rd_en/mem_rd_addr        SRAM read request (S0)
//   mem_rd_state/mem_rd_cnt      SRAM read data (S1)
//   mem_wr_*                     SRAM write (S2)
//   spike_valid/spike_addr       one-cycle spike pulse (S2)
//   busy                         pipe holds an op or a clear sweep is running
//   o_dbg_state                  current FSM state
//
// Handshake: a command transfers on a rising CLK edge where cmd_valid and
// cmd_ready are both high; cmd_ready depends only on the FSM state, so it
// never combinationally depends on cmd_valid.
module if_neuron_pipe
  import if_neuron_pkg::*;
#(
  parameter int N_NEUR                    = 256,
  parameter int POST_NEUR_MEM_WIDTH       = 12,
  parameter int POST_NEUR_SPIKE_CNT_WIDTH = 7,
  parameter int WEIGHT_WIDTH              = 8,
  parameter int LEAK_SH_WIDTH             = 4,
  localparam int ADDR_W                   = $clog2(N_NEUR)
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [1:0]                            cmd_op,
  input  logic [ADDR_W-1:0]                     cmd_addr,
  input  logic [WEIGHT_WIDTH-1:0]               cmd_weight,
  input  logic signed [POST_NEUR_MEM_WIDTH-1:0] cfg_thr,
  input  logic                                  cfg_leak_en,
  input  logic [LEAK_SH_WIDTH-1:0]              cfg_leak_shift,
  input  logic                                  cfg_reset_sub,
  output logic                                  mem_rd_en,
  output logic [ADDR_W-1:0]                     mem_rd_addr,
  input  logic signed [POST_NEUR_MEM_WIDTH-1:0] mem_rd_state,
  input  logic [POST_NEUR_SPIKE_CNT_WIDTH-1:0]  mem_rd_cnt,
  output logic                                  mem_wr_en,
  output logic [ADDR_W-1:0]                     mem_wr_addr,
  output logic signed [POST_NEUR_MEM_WIDTH-1:0] mem_wr_state,
  output logic [POST_NEUR_SPIKE_CNT_WIDTH-1:0]  mem_wr_cnt,
  output logic                                  spike_valid,
  output logic [ADDR_W-1:0]                     spike_addr,
  output logic                                  busy,
  output logic [0:0]                            o_dbg_state
);

  localparam int MEM_W = POST_NEUR_MEM_WIDTH;
  localparam int CNT_W = POST_NEUR_SPIKE_CNT_WIDTH;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_NEUR - 1);

  fsm_state_e              r_state;
  logic [ADDR_W-1:0]       r_sweep_addr;
  pipe_stage_t             r_s1;
  logic                    r_s2_valid;
  logic [ADDR_W-1:0]       r_s2_addr;
  logic signed [MEM_W-1:0] r_s2_state;
  logic [CNT_W-1:0]        r_s2_cnt;
  logic                    r_s2_spike;
  // Copy of last cycle's write: the SRAM returns old data on a
  // read-during-write, so an op two behind the writer must take it from here.
  logic                    r_dw_valid;
  logic [ADDR_W-1:0]       r_dw_addr;
  logic signed [MEM_W-1:0] r_dw_state;
  logic [CNT_W-1:0]        r_dw_cnt;
  logic                    r_busy;

  logic                    w_accept;
  logic                    w_accept_clr;
  logic                    w_inject;
  logic                    w_sweep_last;
  pipe_stage_t             w_s0;
  logic signed [MEM_W-1:0] w_op_state;
  logic [CNT_W-1:0]        w_op_cnt;
  logic signed [MEM_W-1:0] w_alu_state;
  logic [CNT_W-1:0]        w_alu_cnt;
  logic                    w_alu_spike;

  assign cmd_ready    = (r_state == ST_RUN);
  assign w_accept     = cmd_valid && cmd_ready;
  assign w_accept_clr = w_accept && (op_e'(cmd_op) == OP_CLR_ALL);
  assign w_inject     = (r_state == ST_CLEAR);
  assign w_sweep_last = (r_sweep_addr == LAST_ADDR);

  // S0: either the accepted command or, during a sweep, an internal REF.
  always_comb begin
    w_s0 = '0;
    if (w_inject) begin
      w_s0.valid = 1'b1;
      w_s0.op    = OP_REF;
      w_s0.addr  = PIPE_ADDR_W'(r_sweep_addr);
    end else if (w_accept && !w_accept_clr) begin
      w_s0.valid  = 1'b1;
      w_s0.op     = op_e'(cmd_op);
      w_s0.addr   = PIPE_ADDR_W'(cmd_addr);
      w_s0.weight = PIPE_WEIGHT_W'(signed'(cmd_weight));
    end
  end

  assign mem_rd_en   = w_s0.valid;
  assign mem_rd_addr = w_s0.addr[ADDR_W-1:0];

  // S1 operand: newest copy wins (S2 result, then delayed write, then SRAM).
  always_comb begin
    w_op_state = mem_rd_state;
    w_op_cnt   = mem_rd_cnt;
    if (r_s2_valid && (PIPE_ADDR_W'(r_s2_addr) == r_s1.addr)) begin
      w_op_state = r_s2_state;
      w_op_cnt   = r_s2_cnt;
    end else if (r_dw_valid && (PIPE_ADDR_W'(r_dw_addr) == r_s1.addr)) begin
      w_op_state = r_dw_state;
      w_op_cnt   = r_dw_cnt;
    end
  end

  if_neuron_alu #(
    .MEM_W(MEM_W),
    .CNT_W(CNT_W),
    .SH_W (LEAK_SH_WIDTH)
  ) u_alu (
    .i_op        (r_s1.op),
    .i_state     (w_op_state),
    .i_cnt       (w_op_cnt),
    .i_weight    (r_s1.weight),
    .i_thr       (cfg_thr),
    .i_leak_en   (cfg_leak_en),
    .i_leak_shift(cfg_leak_shift),
    .i_reset_sub (cfg_reset_sub),
    .o_state     (w_alu_state),
    .o_cnt       (w_alu_cnt),
    .o_spike     (w_alu_spike)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_RUN;
      r_sweep_addr <= '0;
      r_s1         <= '0;
      r_s2_valid   <= 1'b0;
      r_s2_addr    <= '0;
      r_s2_state   <= '0;
      r_s2_cnt     <= '0;
      r_s2_spike   <= 1'b0;
      r_dw_valid   <= 1'b0;
      r_dw_addr    <= '0;
      r_dw_state   <= '0;
      r_dw_cnt     <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_accept_clr) begin
            r_state      <= ST_CLEAR;
            r_sweep_addr <= '0;
          end
        end
        ST_CLEAR: begin
          r_sweep_addr <= r_sweep_addr + ADDR_W'(1);
          if (w_sweep_last) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase

      r_s1       <= w_s0;
      r_s2_valid <= r_s1.valid;
      r_s2_addr  <= r_s1.addr[ADDR_W-1:0];
      r_s2_state <= w_alu_state;
      r_s2_cnt   <= w_alu_cnt;
      r_s2_spike <= r_s1.valid && w_alu_spike;
      r_dw_valid <= r_s2_valid;
      r_dw_addr  <= r_s2_addr;
      r_dw_state <= r_s2_state;
      r_dw_cnt   <= r_s2_cnt;
      // Next-cycle occupancy: S1 next = S0 now, S2 next = S1 now, plus
      // whether the FSM will be sweeping next cycle.
      r_busy     <= w_s0.valid || r_s1.valid ||
                    (w_inject ? !w_sweep_last : w_accept_clr);
    end
  end

  assign mem_wr_en    = r_s2_valid;
  assign mem_wr_addr  = r_s2_addr;
  assign mem_wr_state = r_s2_state;
  assign mem_wr_cnt   = r_s2_cnt;
  assign spike_valid  = r_s2_valid && r_s2_spike;
  assign spike_addr   = r_s2_addr;
  assign busy         = r_busy;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_if_neuron_pipe.sv
module tb_if_neuron_pipe;

  localparam int NN = 16;
  localparam int AW = 4;
  localparam int MW = 12;
  localparam int CW = 7;
  localparam int WW = 8;
  localparam int SW = 4;
  localparam int PW = 1 + AW + MW + CW;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [AW-1:0]        cmd_addr;
  logic [WW-1:0]        cmd_weight;
  logic signed [MW-1:0] cfg_thr;
  logic                 cfg_leak_en;
  logic [SW-1:0]        cfg_leak_shift;
  logic                 cfg_reset_sub;
  logic                 mem_rd_en;
  logic [AW-1:0]        mem_rd_addr;
  logic signed [MW-1:0] mem_rd_state;
  logic [CW-1:0]        mem_rd_cnt;
  logic                 mem_wr_en;
  logic [AW-1:0]        mem_wr_addr;
  logic signed [MW-1:0] mem_wr_state;
  logic [CW-1:0]        mem_wr_cnt;
  logic                 spike_valid;
  logic [AW-1:0]        spike_addr;
  logic                 busy;
  logic [0:0]           dbg_state;

  if_neuron_pipe #(
    .N_NEUR(NN),
    .POST_NEUR_MEM_WIDTH(MW),
    .POST_NEUR_SPIKE_CNT_WIDTH(CW),
    .WEIGHT_WIDTH(WW),
    .LEAK_SH_WIDTH(SW)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_addr(cmd_addr),
    .cmd_weight(cmd_weight),
    .cfg_thr(cfg_thr),
    .cfg_leak_en(cfg_leak_en),
    .cfg_leak_shift(cfg_leak_shift),
    .cfg_reset_sub(cfg_reset_sub),
    .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_state(mem_rd_state),
    .mem_rd_cnt(mem_rd_cnt),
    .mem_wr_en(mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_state(mem_wr_state),
    .mem_wr_cnt(mem_wr_cnt),
    .spike_valid(spike_valid),
    .spike_addr(spike_addr),
    .busy(busy),
    .o_dbg_state(dbg_state)
  );

  // SRAM: 1-cycle read latency, read-during-write returns old data,
  // plus a preload port for the bench.
  logic signed [MW-1:0] sram_state [NN];
  logic [CW-1:0]        sram_cnt   [NN];
  logic                 pl_en;
  logic [AW-1:0]        pl_addr;
  logic signed [MW-1:0] pl_state;
  logic [CW-1:0]        pl_cnt;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_state <= sram_state[mem_rd_addr];
      mem_rd_cnt   <= sram_cnt[mem_rd_addr];
    end
    if (pl_en) begin
      sram_state[pl_addr] <= pl_state;
      sram_cnt[pl_addr]   <= pl_cnt;
    end else if (mem_wr_en) begin
      sram_state[mem_wr_addr] <= mem_wr_state;
      sram_cnt[mem_wr_addr]   <= mem_wr_cnt;
    end
  end

  // reference model and scoreboard
  int model_state [NN];
  int model_cnt   [NN];
  int thr_i, leak_en_i, shift_i, reset_sub_i;
  logic [PW-1:0] exp_q[$];
  int total;
  int bad;
  int wr_seen;

  function automatic int clamp(input int x);
    int hi, lo;
    hi = (1 << (MW - 1)) - 1;
    lo = -(1 << (MW - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  task automatic push_exp(input int sp, input int addr, input int st, input int c);
    logic [PW-1:0] pkt;
    pkt = {1'(sp), AW'(addr), MW'(st), CW'(c)};
    exp_q.push_back(pkt);
  endtask

  task automatic expect_op(input int op, input int addr, input int w);
    int s, c, v, sp;
    s = model_state[addr];
    c = model_cnt[addr];
    sp = 0;
    case (op)
      0: s = clamp(s + w);
      1: begin
        v = (leak_en_i != 0) ? (s - (s >>> shift_i)) : s;
        if (v >= thr_i) begin
          sp = 1;
          s = (reset_sub_i != 0) ? clamp(v - thr_i) : 0;
          c = (c == (1 << CW) - 1) ? c : c + 1;
        end else begin
          s = v;
        end
      end
      2: begin
        s = 0;
        c = 0;
      end
      default: ;
    endcase
    model_state[addr] = s;
    model_cnt[addr] = c;
    push_exp(sp, addr, s, c);
  endtask

  always @(negedge clk) begin
    logic [PW-1:0] exp_pkt;
    logic [PW-1:0] obs_pkt;
    if (mem_wr_en) begin
      wr_seen++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $error("FAIL unexpected_wr addr=%0d state=%0d exp=none", mem_wr_addr, mem_wr_state);
      end else begin
        exp_pkt = exp_q.pop_front();
        obs_pkt = {spike_valid, mem_wr_addr, mem_wr_state, mem_wr_cnt};
        assert (obs_pkt === exp_pkt) else begin
          bad++;
          $error("FAIL wr_pkt obs=%h exp=%h (spike,addr,state,cnt)", obs_pkt, exp_pkt);
        end
        if (exp_pkt[PW-1]) begin
          total++;
          assert (spike_addr === exp_pkt[PW-2 -: AW]) else begin
            bad++;
            $error("FAIL spike_addr obs=%0d exp=%0d", spike_addr, exp_pkt[PW-2 -: AW]);
          end
        end
      end
    end else if (spike_valid) begin
      total++;
      bad++;
      $error("FAIL spike_without_wr obs=1 exp=0");
    end
  end

  // driver tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_cfg(input int thr, input int leak_en, input int shift, input int rsub);
    thr_i = thr;
    leak_en_i = leak_en;
    shift_i = shift;
    reset_sub_i = rsub;
    cfg_thr = MW'(thr);
    cfg_leak_en = 1'(leak_en);
    cfg_leak_shift = SW'(shift);
    cfg_reset_sub = 1'(rsub);
  endtask

  task automatic preload(input int addr, input int st, input int c);
    pl_en = 1'b1;
    pl_addr = AW'(addr);
    pl_state = MW'(st);
    pl_cnt = CW'(c);
    @(posedge clk);
    #1;
    pl_en = 1'b0;
    model_state[addr] = st;
    model_cnt[addr] = c;
  endtask

  task automatic send(input int op, input int addr, input int w);
    cmd_valid = 1'b1;
    cmd_op = 2'(op);
    cmd_addr = AW'(addr);
    cmd_weight = WW'(w);
    check("cmd_ready_at_send", {31'd0, cmd_ready}, 32'd1);
    if (op != 3) expect_op(op, addr, w);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL drain_timeout left=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
    idle(1);
  endtask

  initial begin
    int base, got, low_cnt, op, addr, w;
    logic rdy_k17, busy_k18, busy_k19, st_k1;
    total = 0;
    bad = 0;
    wr_seen = 0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_addr = '0;
    cmd_weight = '0;
    pl_en = 1'b0;
    pl_addr = '0;
    pl_state = '0;
    pl_cnt = '0;
    set_cfg(250, 0, 0, 0);
    idle(3);
    check("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("rst_spike_valid", {31'd0, spike_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_state_run", {31'd0, dbg_state}, 32'd0);
    for (int a = 0; a < NN; a++) preload(a, 0, 0);

    // SYN x3 back-to-back on one address, then STEP over threshold
    send(0, 5, 100);
    send(0, 5, 100);
    send(0, 5, 100);
    send(1, 5, 0);
    wait_drain();

    // saturation at both rails
    preload(1, 2040, 0);
    preload(2, -2040, 0);
    send(0, 1, 100);
    send(0, 2, -100);
    wait_drain();

    // leak without spike, then subtractive reset
    set_cfg(300, 1, 2, 0);
    preload(3, 200, 0);
    send(1, 3, 0);
    wait_drain();
    set_cfg(300, 0, 0, 1);
    preload(4, 400, 0);
    send(1, 4, 0);
    wait_drain();

    // count saturation, then REF
    set_cfg(300, 0, 0, 0);
    preload(6, 2000, 127);
    send(1, 6, 0);
    send(2, 6, 0);
    wait_drain();

    // delayed-write forwarding: ops two cycles apart on one address
    preload(7, 10, 0);
    send(0, 7, 30);
    idle(1);
    send(0, 7, -70);
    wait_drain();
    check("fwd_sum_model", model_state[7], -30);

    // random mix on a few neurons
    set_cfg(200, 1, 3, 1);
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      addr = $urandom_range(8, 11);
      w = int'($urandom_range(0, 255)) - 128;
      send(op, addr, w);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    wait_drain();

    // CLR_ALL right behind a SYN: SYN completes first, then 16 zero writes
    send(0, 3, 17);
    send(3, 0, 0);
    for (int a = 0; a < NN; a++) begin
      model_state[a] = 0;
      model_cnt[a] = 0;
      push_exp(0, a, 0, 0);
    end
    low_cnt = 0;
    rdy_k17 = 1'b0;
    busy_k18 = 1'b0;
    busy_k19 = 1'b1;
    st_k1 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (!cmd_ready) low_cnt++;
      if (k == 1) st_k1 = dbg_state[0];
      if (k == 17) rdy_k17 = cmd_ready;
      if (k == 18) busy_k18 = busy;
      if (k == 19) busy_k19 = busy;
      @(posedge clk);
      #1;
    end
    check("clr_ready_low_cycles", low_cnt, 16);
    check("clr_state_clear", {31'd0, st_k1}, 32'd1);
    check("clr_ready_back", {31'd0, rdy_k17}, 32'd1);
    check("clr_busy_tail_high", {31'd0, busy_k18}, 32'd1);
    check("clr_busy_low", {31'd0, busy_k19}, 32'd0);
    wait_drain();

    // CLR_ALL interrupted by reset after five writes
    for (int a = 0; a < 5; a++) push_exp(0, a, 0, 0);
    send(3, 0, 0);
    base = wr_seen;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (wr_seen >= base + 5) begin
        got = 1;
        break;
      end
    end
    check("sweep_five_writes", got, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);
    check("state_after_rst", {31'd0, dbg_state}, 32'd0);
    idle(6);
    check("writes_after_rst", wr_seen - base, 5);
    check("queue_after_rst", exp_q.size(), 0);
    check("busy_after_rst", {31'd0, busy}, 32'd0);

    // pipe works normally after the interrupted sweep
    send(0, 9, 55);
    send(0, 9, 5);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
